// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32 immediate generator with valid/ready handshake,
// a 2-entry skid buffer for a registered in_ready, and a saturating illegal-select count.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       Imm_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             imm_err,
    output logic [CNT_W-1:0] err_count
);
    logic signed [31:0] raw;
    logic [XLEN-1:0]    dec_imm;
    logic               dec_err;
    logic               main_valid;
    logic               skid_valid;
    logic [XLEN-1:0]    skid_imm;
    logic               skid_err;
    logic               acc;
    logic               xfer;
    logic               load_main;
    logic               unused_opcode;

    assign unused_opcode = ^instruction[6:0];

    always_comb begin
        raw = (Imm_select == 3'b001) ? {{20{instruction[31]}}, instruction[31:20]} :
              (Imm_select == 3'b010) ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]} :
              (Imm_select == 3'b011) ? {{19{instruction[31]}}, instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0} :
              (Imm_select == 3'b100) ? {instruction[31:12], 12'b0} :
              (Imm_select == 3'b101) ? {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                        instruction[20], instruction[30:21], 1'b0} :
                                       32'sd0;
        dec_imm = XLEN'(raw);
        dec_err = Imm_select[2] & Imm_select[1];
    end

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign acc       = in_valid && in_ready && !flush;
    assign xfer      = main_valid && out_ready;
    assign load_main = !main_valid || xfer;

    // Skid holds an entry only while main is full and stalled; it always drains first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            imm        <= '0;
            imm_err    <= 1'b0;
            skid_imm   <= '0;
            skid_err   <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (load_main) begin
                main_valid <= skid_valid || acc;
                if (skid_valid) begin
                    imm     <= skid_imm;
                    imm_err <= skid_err;
                end else if (acc) begin
                    imm     <= dec_imm;
                    imm_err <= dec_err;
                end
            end
            skid_valid <= skid_valid ? !load_main : (acc && !load_main);
            if (acc && !load_main) begin
                skid_imm <= dec_imm;
                skid_err <= dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (acc && dec_err && err_count != '1)
            err_count <= err_count + 1'b1;
    end
endmodule
